fwnoc_router_egress_arb: RTL and testbench

//  Parametrised egress manager for one fwnoc router output port. Arbitrates N_PORTS

---
 rtl/fwnoc_router_egress_arb.sv | 187 ++++++++++++++++++
 tb/tb_fwnoc_router_egress_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwnoc_router_egress_arb.sv
// fwnoc_router_egress_arb
// Egress manager for one fwnoc router output port. Packets from N_PORTS ready/valid
// ingress streams go onto one egress stream. Each packet is forwarded whole, and
// ports are granted in round-robin order. The payload length is taken from the
// header flit.
// Optional feature macro: FWNOC_EGRESS_PKTCNT_EN (adds the 32-bit packet counter;
// when it is undefined, pkt_count is tied to zero).
`timescale 1ns/1ps

module fwnoc_router_egress_arb #(
   parameter int N_PORTS    = 4,
   parameter int DAT_WIDTH  = 32,
   parameter int SIZE_LSB   = 0,
   parameter int SIZE_WIDTH = 8,
   localparam int IW        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N_PORTS*DAT_WIDTH-1:0] i_dat,
   input  logic [N_PORTS-1:0]           i_valid,
   output logic [N_PORTS-1:0]           i_ready,
   output logic [DAT_WIDTH-1:0]         e_dat,
   output logic                         e_valid,
   input  logic                         e_ready,
   output logic                         busy,
   output logic [IW-1:0]                grant_idx,
   output logic [31:0]                  pkt_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2
   } state_t;

   state_t                 state_q;
   logic [IW-1:0]          grant_q;
   logic [IW-1:0]          rr_q;
   logic [SIZE_WIDTH-1:0]  count_q;

   logic [DAT_WIDTH-1:0]   port_dat_s [N_PORTS];
   logic [IW-1:0]          pick_s;
   logic                   found_s;
   logic [IW:0]            sum_s;
   logic [IW-1:0]          cand_s;
   logic                   hs_s;
   logic                   done_s;
   logic [IW-1:0]          rr_next_s;
   logic [SIZE_WIDTH-1:0]  len_s;

   for (genvar k = 0; k < N_PORTS; k++) begin : g_port
      assign port_dat_s[k] = i_dat[k*DAT_WIDTH +: DAT_WIDTH];
   end

   // Round-robin search: first requesting port at or after rr_q, wrapping modulo N_PORTS
   always_comb begin
      found_s = 1'b0;
      pick_s  = '0;
      sum_s   = '0;
      cand_s  = '0;
      for (int off = 0; off < N_PORTS; off++) begin
         sum_s = {1'b0, rr_q} + (IW+1)'(off);
         if (sum_s >= (IW+1)'(N_PORTS)) begin
            sum_s = sum_s - (IW+1)'(N_PORTS);
         end else begin
            sum_s = sum_s;
         end
         cand_s = sum_s[IW-1:0];
         if (!found_s && i_valid[cand_s]) begin
            found_s = 1'b1;
            pick_s  = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Unregistered pass-through from the granted port; e_valid never depends on e_ready
   always_comb begin
      e_dat   = '0;
      e_valid = 1'b0;
      i_ready = '0;
      if (state_q != ST_IDLE) begin
         e_dat            = port_dat_s[grant_q];
         e_valid          = i_valid[grant_q];
         i_ready[grant_q] = e_ready;
      end else begin
         e_dat   = '0;
         e_valid = 1'b0;
         i_ready = '0;
      end
   end

   assign hs_s  = e_valid & e_ready;
   assign len_s = e_dat[SIZE_LSB +: SIZE_WIDTH];

   // A packet ends on a zero-length header or on the last payload handshake
   always_comb begin
      done_s = 1'b0;
      case (state_q)
         ST_HDR:  done_s = hs_s && (len_s == '0);
         ST_PAY:  done_s = hs_s && (count_q == SIZE_WIDTH'(1));
         default: done_s = 1'b0;
      endcase
   end

   // The pointer moves to the port just after the one that finished
   always_comb begin
      rr_next_s = '0;
      if (grant_q == IW'(N_PORTS - 1)) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = grant_q + IW'(1);
      end
   end

   // Packet FSM: arbitrate in IDLE, then hold the grant until the packet completes
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         count_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (found_s) begin
                  grant_q <= pick_s;
                  state_q <= ST_HDR;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_HDR: begin
               if (hs_s) begin
                  count_q <= len_s;
                  if (done_s) begin
                     rr_q    <= rr_next_s;
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_PAY;
                  end
               end else begin
                  state_q <= ST_HDR;
               end
            end
            ST_PAY: begin
               if (done_s) begin
                  count_q <= count_q - SIZE_WIDTH'(1);
                  rr_q    <= rr_next_s;
                  state_q <= ST_IDLE;
               end else if (hs_s) begin
                  count_q <= count_q - SIZE_WIDTH'(1);
               end else begin
                  count_q <= count_q;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign grant_idx = grant_q;

`ifdef FWNOC_EGRESS_PKTCNT_EN
   logic [31:0] pkt_q;

   // Completed-packet counter; wraps naturally from 2^32-1 to 0
   always_ff @(posedge clock) begin
      if (reset) begin
         pkt_q <= 32'd0;
      end else if (done_s) begin
         pkt_q <= pkt_q + 32'd1;
      end else begin
         pkt_q <= pkt_q;
      end
   end

   assign pkt_count = pkt_q;
`else
   assign pkt_count = 32'd0;
`endif

endmodule

// File: tb/tb_fwnoc_router_egress_arb.sv
// Bench for fwnoc_router_egress_arb (N_PORTS=4, DAT_WIDTH=32, SIZE_WIDTH=8).
// Per-port flit queues feed the DUT with random valid gaps and egress back-pressure.
// A packet-level reference model predicts every cycle's outputs.
`timescale 1ns/1ps

module tb_fwnoc_router_egress_arb;

   logic         clock = 1'b0;
   logic         reset;
   logic [127:0] i_dat;
   logic [3:0]   i_valid;
   logic [3:0]   i_ready;
   logic [31:0]  e_dat;
   logic         e_valid;
   logic         e_ready;
   logic         busy;
   logic [1:0]   grant_idx;
   logic [31:0]  pkt_count;

   fwnoc_router_egress_arb #(
      .N_PORTS    (4),
      .DAT_WIDTH  (32),
      .SIZE_LSB   (0),
      .SIZE_WIDTH (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .i_dat     (i_dat),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .e_dat     (e_dat),
      .e_valid   (e_valid),
      .e_ready   (e_ready),
      .busy      (busy),
      .grant_idx (grant_idx),
      .pkt_count (pkt_count)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;

   // Stimulus: one flit array per port, consumed from head to tail
   logic [31:0] mem [4][1024];
   int          head [4];
   int          tail [4];
   int          seq = 0;

   // Reference model, kept at packet level: whether a packet is in flight, which port
   // owns it, how many payload flits remain, and the next round-robin start port
   bit          m_busy;
   bit          m_hdr;
   bit          m_new;
   logic [1:0]  m_g;
   logic [1:0]  m_rr;
   int          m_left;
   logic [31:0] m_pkts;

   int          glog[$];
   int          obs_flits;
   int          ncyc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit pending();
      for (int k = 0; k < 4; k++) begin
         if (tail[k] > head[k]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic send_pkt(input int p, input int len);
      if (head[p] == tail[p]) begin
         head[p] = 0;
         tail[p] = 0;
      end
      mem[p][tail[p]] = {8'(p), 8'(seq), 8'($urandom), 8'(len)};
      tail[p]++;
      for (int i = 0; i < len; i++) begin
         mem[p][tail[p]] = $urandom;
         tail[p]++;
      end
      seq++;
   endtask

   task automatic clear_queues();
      for (int k = 0; k < 4; k++) begin
         head[k] = 0;
         tail[k] = 0;
      end
   endtask

   // One clock: drive inputs at negedge, check against the model, then advance the model
   task automatic cycle(input bit rst, input int pv, input int pr);
      logic [31:0] exp_pc;
      logic [3:0]  exp_rdy;
      bit          exp_v;
      bit          found;
      int          c;
      logic [31:0] f;
      @(negedge clock);
      reset = rst;
      for (int k = 0; k < 4; k++) begin
         i_valid[k] = (tail[k] > head[k]) && ($urandom_range(99) < pv);
         i_dat[k*32 +: 32] = i_valid[k] ? mem[k][head[k]] : $urandom;
      end
      e_ready = ($urandom_range(99) < pr);
      #1;
      exp_v   = m_busy && i_valid[m_g];
      exp_rdy = 4'd0;
      if (m_busy) exp_rdy[m_g] = e_ready;
`ifdef FWNOC_EGRESS_PKTCNT_EN
      exp_pc = m_pkts;
`else
      exp_pc = 32'd0;
`endif
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("e_valid", 32'(e_valid), 32'(exp_v));
      check_eq("i_ready", 32'(i_ready), 32'(exp_rdy));
      check_eq("grant_idx", 32'(grant_idx), 32'(m_g));
      check_eq("pkt_count", pkt_count, exp_pc);
      if (exp_v) begin
         check_eq("e_dat", e_dat, mem[m_g][head[m_g]]);
      end else if (!m_busy) begin
         check_eq("e_dat_idle", e_dat, 32'd0);
      end
      if (m_new) begin
         glog.push_back(int'(grant_idx));
         m_new = 1'b0;
      end
      if (e_valid && e_ready) obs_flits++;
      if (rst) begin
         m_busy = 1'b0;
         m_hdr  = 1'b0;
         m_new  = 1'b0;
         m_g    = 2'd0;
         m_rr   = 2'd0;
         m_pkts = 32'd0;
      end else if (!m_busy) begin
         found = 1'b0;
         for (int o = 0; o < 4; o++) begin
            c = (int'(m_rr) + o) % 4;
            if (!found && i_valid[c[1:0]]) begin
               found = 1'b1;
               m_g   = c[1:0];
            end
         end
         if (found) begin
            m_busy = 1'b1;
            m_hdr  = 1'b1;
            m_new  = 1'b1;
         end
      end else if (i_valid[m_g] && e_ready) begin
         f = mem[m_g][head[m_g]];
         head[m_g]++;
         if (m_hdr) begin
            m_left = int'(f[7:0]);
            m_hdr  = 1'b0;
         end else begin
            m_left--;
         end
         if (m_left == 0) begin
            m_busy = 1'b0;
            c      = (int'(m_g) + 1) % 4;
            m_rr   = c[1:0];
            m_pkts = m_pkts + 32'd1;
         end
      end
      @(posedge clock);
   endtask

   task automatic drain(input int pv, input int pr, output int n);
      n = 0;
      while ((pending() || m_busy) && n < 5000) begin
         cycle(1'b0, pv, pr);
         n++;
      end
      check_eq("drain_bound", 32'(n < 5000), 32'd1);
   endtask

   task automatic check_glog(input string tag, input int a, input int b);
      check_eq({tag, "_n"}, 32'(glog.size()), 32'd2);
      if (glog.size() >= 2) begin
         check_eq({tag, "_0"}, 32'(glog[0]), 32'(a));
         check_eq({tag, "_1"}, 32'(glog[1]), 32'(b));
      end
   endtask

   initial begin
      int pv;
      int pr;
      reset   = 1'b1;
      i_valid = 4'd0;
      i_dat   = 128'd0;
      e_ready = 1'b0;
      clear_queues();
      m_busy = 1'b0; m_hdr = 1'b0; m_new = 1'b0;
      m_g = 2'd0; m_rr = 2'd0; m_left = 0; m_pkts = 32'd0;
      repeat (2) @(posedge clock);

      // Reset state: idle outputs, grant 0, count 0
      cycle(1'b0, 0, 100);

      // Test 1: port 0, header 3 + 3 payload, full rate: 1 arbitration + 4 flits
      obs_flits = 0;
      send_pkt(0, 3);
      drain(100, 100, ncyc);
      check_eq("t1_cycles", 32'(ncyc), 32'd5);
      check_eq("t1_flits", 32'(obs_flits), 32'd4);
      cycle(1'b0, 100, 100);

      // Test 2: all ports hold zero-length packets, order 0,1,2,3,0 at 2 cycles each
      cycle(1'b1, 0, 100);
      glog.delete();
      send_pkt(0, 0); send_pkt(0, 0);
      send_pkt(1, 0); send_pkt(2, 0); send_pkt(3, 0);
      drain(100, 100, ncyc);
      check_eq("t2_cycles", 32'(ncyc), 32'd10);
      check_eq("t2_ngrants", 32'(glog.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < glog.size()) check_eq("t2_order", 32'(glog[i]), 32'(i % 4));
      end
      cycle(1'b0, 0, 100);

      // Test 3: port 2, 5-flit packet under random back-pressure
      obs_flits = 0;
      send_pkt(2, 4);
      drain(100, 50, ncyc);
      check_eq("t3_flits", 32'(obs_flits), 32'd5);

      // Test 4: port 1 max-length packet; port 3 raises a request mid-packet
      obs_flits = 0;
      glog.delete();
      send_pkt(1, 255);
      repeat (40) cycle(1'b0, 100, 100);
      send_pkt(3, 1);
      drain(100, 100, ncyc);
      check_eq("t4_flits", 32'(obs_flits), 32'd258);
      check_glog("t4_grant", 1, 3);

      // Test 5: reset in PAY with 4 payload flits left, then rr restarts at port 0
      cycle(1'b1, 0, 100);
      send_pkt(2, 0);
      drain(100, 100, ncyc);
      send_pkt(0, 8);
      repeat (6) cycle(1'b0, 100, 100);
      check_eq("t5_left", 32'(m_left), 32'd4);
      cycle(1'b1, 0, 100);
      clear_queues();
      cycle(1'b0, 0, 100);
      check_eq("t5_pkt", pkt_count, 32'd0);
      glog.delete();
      send_pkt(3, 0);
      send_pkt(0, 0);
      drain(100, 100, ncyc);
      check_glog("t5_grant", 0, 3);

      // Randomized traffic with valid gaps, back-pressure and mid-packet arrivals
      for (int r = 0; r < 40; r++) begin
         pv = int'($urandom_range(20, 100));
         pr = int'($urandom_range(20, 100));
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(1) == 1) send_pkt(k, int'($urandom_range(0, 6)));
         end
         repeat (8) cycle(1'b0, pv, pr);
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(3) == 0) send_pkt(k, int'($urandom_range(0, 20)));
         end
         drain(pv, pr, ncyc);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
